// File: rtl/karat_mult_arbiter.sv
// karat_mult_arbiter
// Round-robin front end that shares one karat_mult_recursion multiplier
// among NREQ requesters. Signed operands are reduced to magnitudes for the
// multiplier and the product sign is restored on the way out. A watchdog
// aborts any run that does not finish within TIMEOUT cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a request; req_ready offers the round-robin grant
//   S_CLEAR | one-cycle synchronous clear pulse into the multiplier
//   S_RUN   | multiplier enabled; waiting for m_finish or the watchdog
//   S_RESP  | tagged response held on rsp_* until rsp_ready
module karat_mult_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ),
    localparam int CNTW   = $clog2(TIMEOUT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_prod,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      m_x,
    output logic [WIDTH-1:0]      m_y,
    output logic                  m_reset,
    output logic                  m_enable,
    input  logic [2*WIDTH-1:0]    m_prod,
    input  logic                  m_finish
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ-1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT-1);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic               rsp_valid_d;
    logic [IDW-1:0]     rsp_id_d;
    logic [2*WIDTH-1:0] rsp_prod_d;
    logic               rsp_err_d;
    logic [WIDTH-1:0]   m_x_d, m_y_d;
    logic               m_reset_d, m_enable_d;

    logic [2*NREQ-1:0]  req_dbl;
    logic [NREQ-1:0]    req_rot;
    logic [IDW-1:0]     grant_off;
    logic [IDW:0]       grant_sum;
    logic [IDW-1:0]     grant;
    logic               grant_vld;
    logic               accept;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic [2*WIDTH-1:0] prod_signed;

    // Two's complement magnitude; the most negative value maps to 2^(W-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (-v) : v;
    endfunction

    // Rotate the request vector so that bit 0 is the requester at ptr;
    // the lowest set bit of the rotated vector is the round-robin winner.
    assign req_dbl = {req_valid, req_valid} >> ptr_q;
    assign req_rot = req_dbl[NREQ-1:0];

    // Priority pick over the rotated requests (lowest offset wins).
    always_comb begin
        grant_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_off = IDW'(k);
            end
        end
    end

    assign grant_vld = |req_rot;
    assign grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
    assign grant     = (grant_sum >= NREQ_W) ? IDW'(grant_sum - NREQ_W)
                                             : grant_sum[IDW-1:0];

    assign accept    = (state_q == S_IDLE) && grant_vld;
    // Grant is combinational; gated by reset_n so nothing is offered while
    // reset is held, even before the first clock edge.
    assign req_ready = (accept && reset_n) ? (ONE_HOT0 << grant) : '0;

    assign a_sel       = req_a[grant*WIDTH +: WIDTH];
    assign b_sel       = req_b[grant*WIDTH +: WIDTH];
    assign prod_signed = neg_q ? (-m_prod) : m_prod;

    // Next-state and next-output logic; every registered output is
    // computed here and captured together in the register process.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_prod_d  = rsp_prod;
        rsp_err_d   = rsp_err;
        m_x_d       = m_x;
        m_y_d       = m_y;
        m_reset_d   = 1'b0;
        m_enable_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CLEAR;
                    rsp_id_d  = grant;
                    neg_d     = a_sel[WIDTH-1] ^ b_sel[WIDTH-1];
                    m_x_d     = mag(a_sel);
                    m_y_d     = mag(b_sel);
                    ptr_d     = (grant == LAST_ID) ? '0 : grant + IDW'(1);
                    m_reset_d = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d    = S_RUN;
                cnt_d      = '0;
                m_enable_d = 1'b1;
            end
            S_RUN: begin
                m_enable_d = 1'b1;
                if (m_finish) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_prod_d  = prod_signed;
                    rsp_err_d   = 1'b0;
                    m_enable_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_prod_d  = '0;
                    rsp_err_d   = 1'b1;
                    m_enable_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pointer, watchdog and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_err   <= 1'b0;
            m_x       <= '0;
            m_y       <= '0;
            m_reset   <= 1'b0;
            m_enable  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_prod  <= rsp_prod_d;
            rsp_err   <= rsp_err_d;
            m_x       <= m_x_d;
            m_y       <= m_y_d;
            m_reset   <= m_reset_d;
            m_enable  <= m_enable_d;
        end
    end

endmodule

// File: tb/tb_karat_mult_arbiter.sv
// Bench for karat_mult_arbiter: directed cases from the test plan followed by
// randomized traffic, with a behavioural multiplier stand-in.
module tb_karat_mult_arbiter;

    localparam int WIDTH   = 16;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;
    logic                  rsp_err;
    logic [WIDTH-1:0]      m_x, m_y;
    logic                  m_reset, m_enable;
    logic [2*WIDTH-1:0]    m_prod;
    logic                  m_finish;

    karat_mult_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .rsp_err   (rsp_err),
        .m_x       (m_x),
        .m_y       (m_y),
        .m_reset   (m_reset),
        .m_enable  (m_enable),
        .m_prod    (m_prod),
        .m_finish  (m_finish)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] prod;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    // Reference state
    bit              mul_dead = 1'b0;
    bit              rand_bp  = 1'b0;
    bit              busy;
    int              mptr;
    int              phase;
    int              en_cnt;
    bit              fin_prev;
    bit              rsp_held;
    logic [IDW-1:0]  h_id;
    logic [31:0]     h_prod;
    logic            h_err;
    logic [15:0]     cap_x, cap_y;
    int              g, idx, a_i, b_i;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;

    // Multiplier stand-in: random latency, unsigned magnitude product.
    int mcnt, mlat;
    always begin
        @(posedge clk);
        #3;
        if (!reset_n || m_reset) begin
            mcnt     = 0;
            m_finish = 1'b0;
            m_prod   = '0;
            mlat     = $urandom_range(1, 6);
        end else if (m_enable) begin
            mcnt++;
            if (!mul_dead && mcnt >= mlat) begin
                m_finish = 1'b1;
                m_prod   = 32'(m_x) * 32'(m_y);
            end
        end else begin
            m_finish = 1'b0;
        end
    end

    // Requesters drop req_valid once their request is taken.
    logic [NREQ-1:0] acc;
    always begin
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    end

    // Random response backpressure.
    always begin
        @(posedge clk);
        #2;
        if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            busy     = 1'b0;
            mptr     = 0;
            phase    = 0;
            en_cnt   = 0;
            fin_prev = 1'b0;
            rsp_held = 1'b0;
        end else begin
            if (m_enable) en_cnt++;
            if (fin_prev) chk("rsp_latency", rsp_valid, 1'b1);
            fin_prev = m_finish && m_enable;

            if (phase == 2) begin
                chk("m_reset_off", m_reset, 1'b0);
                chk("m_enable_on", m_enable, 1'b1);
                phase = 0;
            end
            if (phase == 1) begin
                chk("m_reset_pulse", m_reset, 1'b1);
                chk("m_enable_low", m_enable, 1'b0);
                chk("m_x", m_x, cap_x);
                chk("m_y", m_y, cap_y);
                phase = 2;
            end

            if (!busy) begin
                g = -1;
                exp_rdy = '0;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (mptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
                chk("req_ready", req_ready, exp_rdy);
                if (g >= 0) begin
                    a_i    = int'($signed(req_a[g*WIDTH +: WIDTH]));
                    b_i    = int'($signed(req_b[g*WIDTH +: WIDTH]));
                    e.id   = g;
                    e.err  = mul_dead;
                    e.prod = mul_dead ? 32'd0 : 32'(longint'(a_i) * longint'(b_i));
                    sb_q.push_back(e);
                    cap_x  = 16'((a_i < 0) ? -a_i : a_i);
                    cap_y  = 16'((b_i < 0) ? -b_i : b_i);
                    busy   = 1'b1;
                    mptr   = (g + 1) % NREQ;
                    phase  = 1;
                    en_cnt = 0;
                end
            end else begin
                chk("req_ready_busy", req_ready, '0);
            end

            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", rsp_valid, 1'b0);
            end else if (rsp_valid) begin
                if (!rsp_held) begin
                    e = sb_q[0];
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_prod", rsp_prod, e.prod);
                    chk("rsp_err", rsp_err, e.err);
                    if (e.err) chk("wd_enable_cycles", en_cnt, TIMEOUT);
                    h_id     = rsp_id;
                    h_prod   = rsp_prod;
                    h_err    = rsp_err;
                    rsp_held = 1'b1;
                end else begin
                    chk("rsp_stable_id", rsp_id, h_id);
                    chk("rsp_stable_prod", rsp_prod, h_prod);
                    chk("rsp_stable_err", rsp_err, h_err);
                end
                if (rsp_ready) begin
                    void'(sb_q.pop_front());
                    busy     = 1'b0;
                    rsp_held = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int id, input int a, input int b);
        int w = 0;
        while (req_valid[id] && w < 2000) begin
            cyc();
            w++;
        end
        if (req_valid[id]) chk("issue_wait", req_valid[id], 1'b0);
        req_a[id*WIDTH +: WIDTH] = 16'(a);
        req_b[id*WIDTH +: WIDTH] = 16'(b);
        req_valid[id] = 1'b1;
    endtask

    task automatic drain(input int budget);
        int w = 0;
        while ((req_valid != '0 || sb_q.size() != 0 || rsp_valid) && w < budget) begin
            cyc();
            w++;
        end
        if (w >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding after %0d cycles", sb_q.size(), w);
        end
        cyc();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, '0);
        chk("rst_rsp_prod", rsp_prod, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_m_x", m_x, '0);
        chk("rst_m_y", m_y, '0);
        chk("rst_m_reset", m_reset, 1'b0);
        chk("rst_m_enable", m_enable, 1'b0);
    endtask

    function automatic int rand_op();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0:       return -32768;
            1:       return 32767;
            2:       return 0;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete, %0d responses outstanding", sb_q.size());
        $fatal(1, "time limit reached");
    end

    initial begin
        int w;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        m_finish  = 1'b0;
        m_prod    = '0;
        repeat (3) cyc();
        req_valid = 4'b0101;
        #1;
        chk_reset_outputs();
        req_valid = '0;
        cyc();
        reset_n = 1'b1;
        cyc();

        issue(0, 123, 456);
        drain(200);
        issue(1, 123, -456);
        drain(200);

        issue(2, -32768, -32768);
        drain(200);
        issue(3, -32768, 32767);
        drain(200);
        issue(3, 0, -5);
        drain(200);

        issue(0, 11, -3);
        issue(1, -250, -4);
        issue(2, 999, 7);
        issue(3, -1, 1);
        drain(400);
        issue(0, 300, 301);
        issue(2, -12345, 2);
        drain(300);

        rsp_ready = 1'b0;
        issue(3, 1000, -3);
        issue(1, -77, 77);
        w = 0;
        while (!rsp_valid && w < 100) begin
            cyc();
            w++;
        end
        chk("stall_rsp_seen", rsp_valid, 1'b1);
        repeat (5) begin
            cyc();
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_no_grant", req_ready, '0);
        end
        rsp_ready = 1'b1;
        drain(300);

        mul_dead = 1'b1;
        issue(2, 100, 200);
        drain(300);
        mul_dead = 1'b0;
        issue(0, 5, -6);
        drain(200);

        mul_dead = 1'b1;
        issue(1, 11, 22);
        w = 0;
        while (!m_enable && w < 50) begin
            cyc();
            w++;
        end
        chk("run_reached", m_enable, 1'b1);
        repeat (3) cyc();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs();
        cyc();
        cyc();
        reset_n  = 1'b1;
        mul_dead = 1'b0;
        repeat (4) begin
            cyc();
            chk("no_rsp_after_reset", rsp_valid, 1'b0);
        end
        issue(2, 7, -9);
        drain(200);

        rand_bp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            issue($urandom_range(0, NREQ - 1), rand_op(), rand_op());
            if ($urandom_range(0, 2) == 0) cyc();
        end
        drain(4000);
        rand_bp   = 1'b0;
        rsp_ready = 1'b1;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/karat_mult_arbiter.md
# karat_mult_arbiter

Round-robin scheduler that shares one `karat_mult_recursion` instance among NREQ requesters. It accepts signed operand pairs and runs the multiplier on operand magnitudes. Each operation is sequenced as clear, enable, then wait for finish; the product sign is restored afterwards. The result returns on a single tagged response channel, and a watchdog bounds every run.

## Interface
- WIDTH, 16, operand width (signed two's complement)
- NREQ, 4, number of requesters (≥2); IDW = $clog2(NREQ)
- TIMEOUT, 64, maximum RUN cycles before abort (≥2)
- clk  in  1  clock; everything on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending, bit i = requester i
- req_ready  out  NREQ  one-hot grant/accept
- req_a, req_b  in  NREQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  IDW  requester index of response
- rsp_prod  out  2*WIDTH  signed product a*b
- rsp_err  out  1  run aborted by watchdog
- m_x, m_y  out  WIDTH  unsigned magnitudes to multiplier iX/iY
- m_reset  out  1  active-high synchronous clear to multiplier reset
- m_enable  out  1  to multiplier i_enable
- m_prod  in  2*WIDTH  multiplier oO (unsigned magnitude product)
- m_finish  in  1  multiplier o_finish

## Operation
- States: IDLE, CLEAR, RUN, RESP.
- Round-robin pointer ptr (IDW bits, reset 0).
- IDLE: grant = first i with req_valid[i], searching ptr, ptr+1, … with wrap mod NREQ.
  - req_ready[grant] = 1, combinational from req_valid and ptr; all other bits 0.
  - On req_valid&req_ready: latch id, neg = a[W-1]^b[W-1], m_x = |a|, m_y = |b| (WIDTH-bit unsigned; -2^(W-1) maps to 2^(W-1)).
  - Then ptr = grant+1 mod NREQ; next state CLEAR.
- CLEAR (1 cycle): m_reset=1, m_enable=0. Next state RUN, watchdog counter = 0.
- RUN: m_enable=1, m_reset=0, counter increments each cycle.
  - m_finish=1 sampled: rsp_prod = neg ? -m_prod : m_prod (2W-bit two's complement; zero stays zero), rsp_err=0 → RESP.
  - Else, counter reaching TIMEOUT-1: rsp_prod=0, rsp_err=1 → RESP.
  - m_finish and timeout in the same cycle: finish wins.
- RESP: rsp_valid=1, m_enable=0. rsp_id/rsp_prod/rsp_err stable until rsp_valid&rsp_ready, then IDLE.
- req_ready is all-zero outside IDLE. m_finish is ignored outside RUN. m_x/m_y hold from capture through RESP.
- Reset mid-operation: state IDLE, ptr 0, in-flight request dropped with no response. The next CLEAR flushes the multiplier.

## Timing
- Reset values: state IDLE, req_ready 0 (forced while reset_n low), rsp_valid 0, rsp_id 0, rsp_prod 0, rsp_err 0, m_x 0, m_y 0, m_reset 0, m_enable 0, ptr 0, counter 0.
- Accept at edge T0; m_reset high in cycle T0+1; m_enable high from T0+2.
- m_finish sampled high at edge Tf → rsp_valid high from Tf+1.
- Response accepted at edge Tr → earliest next grant in cycle Tr+1 (one IDLE cycle, no back-to-back accept).
- Timeout: exactly TIMEOUT cycles with m_enable=1, then rsp_valid with rsp_err=1.
- Registered outputs: everything except req_ready.

## Test plan
- Single request: WIDTH=16, req0 a=123, b=456 → rsp_id=0, rsp_prod=56088, rsp_err=0; m_reset is exactly one cycle before m_enable rises.
- Negative operand: req1 a=123, b=-456 → m_y=456, rsp_id=1, rsp_prod=-56088 (0xFFFF24E8).
- Extremes:
  - a=-32768, b=-32768 → 1073741824 (0x40000000).
  - a=-32768, b=32767 → -1073709056.
  - a=0, b=-5 → 0.
- Arbitration: all four req_valid high with distinct operands → responses in id order 0,1,2,3. Then req0 and req2 valid → 0 then 2. rsp_ready held low 5 cycles on one response → rsp_valid and all fields stable, no new req_ready.
- Watchdog: m_finish tied 0, TIMEOUT=64 → m_enable high exactly 64 cycles, then rsp_err=1, rsp_prod=0. The next request with a working multiplier completes normally.
- Reset mid-RUN: reset_n low 2 cycles during RUN → all outputs at reset values immediately, no response for the dropped request. A subsequent req2 a=7, b=-9 → rsp_id=2, rsp_prod=-63.
